// File: rtl/pattern_generator.sv
// rtl/pattern_generator.sv - serial bit-pattern transmitter with repeat count and idle gap
module pattern_generator #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [CNT_W-1:0] repeat_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             frame_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] pat, pat_n;
    logic [IDX_W-1:0] len_m1, len_m1_n;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
    logic [GAP_W-1:0] gap_len, gap_len_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             d_n, valid_n, frame_n, busy_n, done_n;

    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] len_eff_m1;
    logic [IDX_W-1:0] start_idx;
    logic [PAT_W-1:0] pat_shr;

    // Out-of-range lengths (0 or wider than the register) fall back to the full width
    always_comb begin
        if (len_i == '0 || len_i > LEN_W'(PAT_W)) len_eff = LEN_W'(PAT_W);
        else                                       len_eff = len_i;
        len_eff_m1 = len_eff - LEN_W'(1);
        start_idx  = len_eff_m1[IDX_W-1:0];
    end

    // Next-state and next-output decode; outputs are registered so they show what the next cycle emits
    always_comb begin
        state_n   = state;
        pat_n     = pat;
        len_m1_n  = len_m1;
        rep_cnt_n = rep_cnt;
        gap_len_n = gap_len;
        gap_cnt_n = gap_cnt;
        idx_n     = idx;
        d_n       = 1'b0;
        valid_n   = 1'b0;
        frame_n   = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        pat_shr   = '0;

        if (abort_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state_n   = SHIFT;
                        pat_n     = pattern_i;
                        len_m1_n  = start_idx;
                        rep_cnt_n = repeat_i;
                        gap_len_n = gap_i;
                        idx_n     = start_idx;
                        pat_shr   = pattern_i >> start_idx;
                        d_n       = pat_shr[0];
                        valid_n   = 1'b1;
                        frame_n   = 1'b1;
                        busy_n    = 1'b1;
                    end
                end
                SHIFT: begin
                    if (idx == '0) begin
                        if (rep_cnt != '0) begin
                            rep_cnt_n = rep_cnt - CNT_W'(1);
                            busy_n    = 1'b1;
                            if (gap_len != '0) begin
                                state_n   = GAP;
                                gap_cnt_n = gap_len;
                            end else begin
                                idx_n   = len_m1;
                                pat_shr = pat >> len_m1;
                                d_n     = pat_shr[0];
                                valid_n = 1'b1;
                                frame_n = 1'b1;
                            end
                        end else begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        idx_n   = idx - IDX_W'(1);
                        pat_shr = pat >> idx_n;
                        d_n     = pat_shr[0];
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                    end
                end
                GAP: begin
                    busy_n = 1'b1;
                    if (gap_cnt == GAP_W'(1)) begin
                        state_n = SHIFT;
                        idx_n   = len_m1;
                        pat_shr = pat >> len_m1;
                        d_n     = pat_shr[0];
                        valid_n = 1'b1;
                        frame_n = 1'b1;
                    end else begin
                        gap_cnt_n = gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, latched fields, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            pat     <= '0;
            len_m1  <= '0;
            rep_cnt <= '0;
            gap_len <= '0;
            gap_cnt <= '0;
            idx     <= '0;
            d_o     <= 1'b0;
            valid_o <= 1'b0;
            frame_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state   <= state_n;
            pat     <= pat_n;
            len_m1  <= len_m1_n;
            rep_cnt <= rep_cnt_n;
            gap_len <= gap_len_n;
            gap_cnt <= gap_cnt_n;
            idx     <= idx_n;
            d_o     <= d_n;
            valid_o <= valid_n;
            frame_o <= frame_n;
            busy_o  <= busy_n;
            done_o  <= done_n;
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// tb/tb_pattern_generator.sv - scoreboard bench for pattern_generator
module tb_pattern_generator;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] pattern_i = '0;
    logic [3:0] len_i = '0;
    logic [7:0] repeat_i = '0;
    logic [3:0] gap_i = '0;
    logic       d_o, valid_o, frame_o, busy_o, done_o;

    int vectors = 0;
    int errors = 0;
    int cyc;
    logic [4:0] sb[$];
    logic [4:0] exp_v, got_v;

    pattern_generator dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .pattern_i(pattern_i), .len_i(len_i), .repeat_i(repeat_i), .gap_i(gap_i),
        .d_o(d_o), .valid_o(valid_o), .frame_o(frame_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected per-cycle {d, valid, frame, busy, done} for a full run starting at cycle 1
    task automatic push_run(input logic [7:0] pat, input int len, input int rep, input int gap);
        int l;
        l = (len == 0 || len > 8) ? 8 : len;
        for (int f = 0; f <= rep; f++) begin
            for (int b = l - 1; b >= 0; b--)
                sb.push_back({pat[b], 1'b1, (b == l - 1), 1'b1, 1'b0});
            if (f < rep)
                for (int g = 0; g < gap; g++) sb.push_back(5'b00010);
        end
        sb.push_back(5'b00001);
        sb.push_back(5'b00000);
    endtask

    task automatic drive_start(input logic [7:0] pat, input logic [3:0] len,
                               input logic [7:0] rep, input logic [3:0] gap);
        pattern_i = pat; len_i = len; repeat_i = rep; gap_i = gap; start_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_i = i[0];
            pattern_i = 8'hFF;
            sb.push_back(5'b00000);
        end
        cyc = 1;
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            exp_v = sb.pop_front();
            got_v = {d_o, valid_o, frame_o, busy_o, done_o};
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %b exp %b", cyc, got_v, exp_v);
            end
            start_i = ~start_i;
            cyc++;
        end
        start_i = 1'b0;
        rst_i = 1'b1;
        repeat (2) sb.push_back(5'b00000);
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            exp_v = sb.pop_front();
            got_v = {d_o, valid_o, frame_o, busy_o, done_o};
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_release got %b exp %b", got_v, exp_v);
            end
        end
    endtask

    task automatic run_and_check(input string name);
        cyc = 1;
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            exp_v = sb.pop_front();
            got_v = {d_o, valid_o, frame_o, busy_o, done_o};
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s cyc %0d got %b exp %b", name, cyc, got_v, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_single();
        drive_start(8'h1B, 4'd5, 8'd0, 4'd0);
        push_run(8'h1B, 5, 0, 0);
        run_and_check("single");
    endtask

    task automatic test_repeat_gap();
        drive_start(8'h1B, 4'd5, 8'd2, 4'd3);
        push_run(8'h1B, 5, 2, 3);
        run_and_check("repeat_gap");
    endtask

    task automatic test_back_to_back();
        drive_start(8'h05, 4'd3, 8'd1, 4'd0);
        push_run(8'h05, 3, 1, 0);
        run_and_check("back_to_back");
        drive_start(8'h01, 4'd1, 8'd255, 4'd0);
        push_run(8'h01, 1, 255, 0);
        run_and_check("repeat_max");
    endtask

    task automatic test_len_clamp();
        drive_start(8'hA5, 4'd0, 8'd0, 4'd0);
        push_run(8'hA5, 0, 0, 0);
        run_and_check("len_zero");
        drive_start(8'hA5, 4'd9, 8'd0, 4'd0);
        push_run(8'hA5, 9, 0, 0);
        run_and_check("len_nine");
    endtask

    task automatic test_start_busy();
        drive_start(8'h1B, 4'd5, 8'd0, 4'd0);
        push_run(8'h1B, 5, 0, 0);
        cyc = 1;
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            start_i = (cyc >= 2 && cyc <= 5);
            pattern_i = 8'hF0; len_i = 4'd8; repeat_i = 8'd3;
            exp_v = sb.pop_front();
            got_v = {d_o, valid_o, frame_o, busy_o, done_o};
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL start_busy cyc %0d got %b exp %b", cyc, got_v, exp_v);
            end
            cyc++;
        end
        start_i = 1'b0;
    endtask

    task automatic test_abort();
        drive_start(8'hA5, 4'd8, 8'd1, 4'd2);
        sb.push_back(5'b11110);
        sb.push_back(5'b01010);
        sb.push_back(5'b11010);
        repeat (4) sb.push_back(5'b00000);
        cyc = 1;
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            exp_v = sb.pop_front();
            got_v = {d_o, valid_o, frame_o, busy_o, done_o};
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL abort cyc %0d got %b exp %b", cyc, got_v, exp_v);
            end
            abort_i = (cyc == 3);
            cyc++;
        end
        abort_i = 1'b0;
        drive_start(8'hFF, 4'd4, 8'd0, 4'd0);
        abort_i = 1'b1;
        repeat (3) sb.push_back(5'b00000);
        run_and_check("abort_vs_start");
        abort_i = 1'b0;
    endtask

    task automatic test_async_reset();
        drive_start(8'hFF, 4'd8, 8'd0, 4'd0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        got_v = {d_o, valid_o, frame_o, busy_o, done_o};
        vectors++;
        if (got_v !== 5'b11010) begin
            errors++;
            $display("FAIL async_pre got %b exp %b", got_v, 5'b11010);
        end
        #2 rst_i = 1'b0;
        #1;
        got_v = {d_o, valid_o, frame_o, busy_o, done_o};
        vectors++;
        if (got_v !== 5'b00000) begin
            errors++;
            $display("FAIL async_drop got %b exp %b", got_v, 5'b00000);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (3) sb.push_back(5'b00000);
        run_and_check("async_idle");
        drive_start(8'h1B, 4'd5, 8'd0, 4'd1);
        push_run(8'h1B, 5, 0, 1);
        run_and_check("async_recover");
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_gap();
        test_back_to_back();
        test_len_clamp();
        test_start_busy();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
